// File: rtl/edge_detect_mc_if.sv
// Control/status bundle for the multi-channel edge detector.
// master drives configuration and raw inputs, slave returns status.
interface edge_detect_mc_if #(
  parameter int CH     = 4,
  parameter int FILT_W = 4
);
  logic              en;
  logic [CH-1:0]     data_in;
  logic [CH-1:0]     invert;
  logic [FILT_W-1:0] filt_len;
  logic [2*CH-1:0]   edge_mode;
  logic [CH-1:0]     clr;
  logic [CH-1:0]     level;
  logic [CH-1:0]     pos_edge;
  logic [CH-1:0]     neg_edge;
  logic [CH-1:0]     evt;
  logic [CH-1:0]     sticky;
  logic              irq;

  modport master (
    output en, data_in, invert,
    output filt_len, edge_mode, clr,
    input  level, pos_edge, neg_edge,
    input  evt, sticky, irq
  );

  modport slave (
    input  en, data_in, invert,
    input  filt_len, edge_mode, clr,
    output level, pos_edge, neg_edge,
    output evt, sticky, irq
  );
endinterface

// File: rtl/edge_detect_mc.sv
// Multi-channel synchronised, glitch-filtered edge detector
// with per-channel event mode, sticky W1C flags and combined irq.
module edge_detect_mc #(
  parameter int            CH     = 4,
  parameter int            SYNC   = 2,
  parameter int            FILT_W = 4,
  parameter logic [CH-1:0] INIT   = '0
) (
  input logic             clk,
  input logic             rst_n,
  edge_detect_mc_if.slave bus
);

  logic [SYNC-1:0]   sync_q [CH];
  logic [FILT_W-1:0] cnt_q  [CH];
  logic [CH-1:0]     level_q;
  logic [CH-1:0]     pos_q;
  logic [CH-1:0]     neg_q;
  logic [CH-1:0]     evt_q;
  logic [CH-1:0]     sticky_q;
  logic              irq_q;
  logic [CH-1:0]     s;
  logic [FILT_W-1:0] lm1;

  // filt_len of 0 behaves as 1, so the accept threshold is L-1
  assign lm1 = (bus.filt_len == '0) ? '0
             : bus.filt_len - 1'b1;

  always_comb begin
    s = '0;
    for (int i = 0; i < CH; i++)
      s[i] = sync_q[i][SYNC-1] ^ bus.invert[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        sync_q[i] <= {SYNC{INIT[i]}};
        cnt_q[i]  <= '0;
      end
      level_q  <= INIT;
      pos_q    <= '0;
      neg_q    <= '0;
      evt_q    <= '0;
      sticky_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      // a new event wins over a simultaneous clear
      sticky_q <= evt_q | (sticky_q & ~bus.clr);
      irq_q    <= |sticky_q;
      pos_q    <= '0;
      neg_q    <= '0;
      evt_q    <= '0;
      for (int i = 0; i < CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC-2:0],
                      bus.data_in[i]};
        if (!bus.en) begin
          cnt_q[i] <= '0;
        end else if (s[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] >= lm1) begin
          level_q[i] <= s[i];
          cnt_q[i]   <= '0;
          pos_q[i]   <= s[i];
          neg_q[i]   <= ~s[i];
          evt_q[i]   <= s[i] ? bus.edge_mode[2*i]
                             : bus.edge_mode[2*i+1];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign bus.level    = level_q;
  assign bus.pos_edge = pos_q;
  assign bus.neg_edge = neg_q;
  assign bus.evt      = evt_q;
  assign bus.sticky   = sticky_q;
  assign bus.irq      = irq_q;

endmodule
